execute_unit: RTL and testbench

//  Execute stage directly downstream of the 8-entry x 8-bit register file.

---
 rtl/execute_unit.sv | 153 +++++++++++++++
 tb/tb_execute_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_unit.sv
// Execute stage behind the 8x8 register file: single-cycle ALU ops plus iterative
// shifts and shift-add multiply, handing result/destination/write strobe back to the file.
module execute_unit #(
  parameter int WIDTH = 8,
  parameter int RIDX  = 3
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [RIDX-1:0]  destIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             regWrite,
  output logic [RIDX-1:0]  writeRegister,
  output logic             zeroFlag,
  output logic             carryFlag,
  output logic             ltFlag
);

  // state | meaning
  // IDLE  | waiting for start; single-cycle ops complete on the accepting edge
  // ITER  | shift/multiply stepping, one step per edge until count reaches zero
  // DONE  | done (and regWrite unless CMP) high for this one cycle
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [RIDX-1:0]  dest_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] iter_res;
  logic             is_iter;

  assign sum_w    = {1'b0, operandA} + {1'b0, operandB};
  assign diff_w   = {1'b0, operandA} - {1'b0, operandB};
  assign is_iter  = (aluOp == OP_SHL) || (aluOp == OP_SHR) || (aluOp == OP_MUL);
  assign iter_res = (op_q == OP_MUL) ? acc_q : a_q;

  always_comb begin
    alu_res = sum_w[WIDTH-1:0];
    case (aluOp)
      OP_SUB, OP_CMP: alu_res = diff_w[WIDTH-1:0];
      OP_AND:         alu_res = operandA & operandB;
      OP_XOR:         alu_res = operandA ^ operandB;
      default:        alu_res = sum_w[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      dest_q        <= '0;
      count_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      zeroFlag      <= 1'b0;
      carryFlag     <= 1'b0;
      ltFlag        <= 1'b0;
    end else begin
      done     <= 1'b0;
      regWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= aluOp;
            a_q    <= operandA;
            b_q    <= operandB;
            dest_q <= destIn;
            busy   <= 1'b1;
            if (is_iter) begin
              state <= ITER;
              acc_q <= '0;
              if (aluOp == OP_MUL) count_q <= CW'(WIDTH);
              else                 count_q <= CW'(operandB[SW-1:0]);
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              zeroFlag <= (alu_res == '0);
              if (aluOp == OP_ADD) carryFlag <= sum_w[WIDTH];
              if (aluOp == OP_SUB || aluOp == OP_CMP) begin
                carryFlag <= ~diff_w[WIDTH];
                ltFlag    <= diff_w[WIDTH];
              end
              // CMP only updates flags; result and write port stay untouched
              if (aluOp != OP_CMP) begin
                result        <= alu_res;
                regWrite      <= 1'b1;
                writeRegister <= destIn;
              end
            end
          end
        end
        ITER: begin
          if (count_q != '0) begin
            count_q <= count_q - CW'(1);
            case (op_q)
              OP_SHL: a_q <= a_q << 1;
              OP_SHR: a_q <= a_q >> 1;
              OP_MUL: begin
                if (b_q[0]) acc_q <= acc_q + a_q;
                a_q <= a_q << 1;
                b_q <= b_q >> 1;
              end
              default: a_q <= a_q;
            endcase
          end else begin
            state         <= DONE;
            done          <= 1'b1;
            regWrite      <= 1'b1;
            writeRegister <= dest_q;
            result        <= iter_res;
            zeroFlag      <= (iter_res == '0);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed vector table, handshake corner
// sequences and randomized ops against a plain-arithmetic reference model.
module tb_execute_unit;

  logic       clock = 1'b0;
  logic       resetN;
  logic       start;
  logic [2:0] aluOp;
  logic [7:0] operandA;
  logic [7:0] operandB;
  logic [2:0] destIn;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       regWrite;
  logic [2:0] writeRegister;
  logic       zeroFlag;
  logic       carryFlag;
  logic       ltFlag;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (what the flags/result should hold between ops)
  int m_res;
  bit m_z, m_c, m_lt;

  execute_unit #(.WIDTH(8), .RIDX(3)) dut (
    .clock(clock), .resetN(resetN), .start(start), .aluOp(aluOp),
    .operandA(operandA), .operandB(operandB), .destIn(destIn),
    .busy(busy), .done(done), .result(result), .regWrite(regWrite),
    .writeRegister(writeRegister), .zeroFlag(zeroFlag),
    .carryFlag(carryFlag), .ltFlag(ltFlag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] d;
    logic [7:0] res;
    int         lat;
    bit         z, c, lt, wr;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_res = 0; m_z = 0; m_c = 0; m_lt = 0;
  endtask

  task automatic model_op(input int op, input int a, input int b, output int lat, output bit wr);
    int r;
    int k;
    k   = b % 8;
    wr  = 1;
    lat = 1;
    r   = m_res;
    case (op)
      0: begin r = (a + b) % 256; m_c = (a + b) > 255; end
      1: begin r = (a - b + 256) % 256; m_c = (a >= b); m_lt = (a < b); end
      2: r = a & b;
      3: r = a ^ b;
      4: begin r = (a * (1 << k)) % 256; lat = k + 2; end
      5: begin r = a / (1 << k); lat = k + 2; end
      6: begin r = (a * b) % 256; lat = 10; end
      default: begin m_c = (a >= b); m_lt = (a < b); wr = 0; end
    endcase
    if (op == 7) m_z = (a == b);
    else begin
      m_z   = (r == 0);
      m_res = r;
    end
  endtask

  // Called at a negedge with the DUT idle; issues one op and checks its completion.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] d, input bit scr, input int e_res, input int e_lat,
                        input bit e_z, input bit e_c, input bit e_lt, input bit e_wr);
    int cyc;
    aluOp = op; operandA = a; operandB = b; destIn = d; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 12) begin
      check("busy_during_op", busy, 1);
      if (scr) begin
        operandA = 8'($urandom);
        operandB = 8'($urandom);
        destIn   = 3'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    check("latency", cyc, e_lat);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 1);
    check("regWrite", regWrite, e_wr);
    if (e_wr) check("writeRegister", writeRegister, d);
    check("result", result, e_res);
    check("zeroFlag", zeroFlag, e_z);
    check("carryFlag", carryFlag, e_c);
    check("ltFlag", ltFlag, e_lt);
    @(negedge clock);
    check("done_drops", done, 0);
    check("busy_drops", busy, 0);
    check("regWrite_drops", regWrite, 0);
  endtask

  initial begin
    int lat;
    bit wr;
    int ndone;
    int done_cyc;

    tbl[0]  = '{3'd0, 8'd200, 8'd100, 3'd3, 8'd44,   1,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{3'd1, 8'd5,   8'd7,   3'd1, 8'd254,  1,  1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{3'd7, 8'd9,   8'd9,   3'd2, 8'd254,  1,  1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{3'd4, 8'h81,  8'd3,   3'd4, 8'h08,   5,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{3'd5, 8'h80,  8'd0,   3'd5, 8'h80,   2,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{3'd6, 8'd13,  8'd11,  3'd6, 8'd143,  10, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{3'd6, 8'd20,  8'd20,  3'd7, 8'd144,  10, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{3'd2, 8'hF0,  8'h0F,  3'd0, 8'd0,    1,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{3'd3, 8'h5A,  8'h5A,  3'd1, 8'd0,    1,  1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{3'd5, 8'h80,  8'd7,   3'd2, 8'd1,    9,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{3'd0, 8'd0,   8'd0,   3'd3, 8'd0,    1,  1'b1, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{3'd1, 8'd7,   8'd5,   3'd4, 8'd2,    1,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{3'd6, 8'd255, 8'd255, 3'd5, 8'd1,    10, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{3'd4, 8'hFF,  8'h0F,  3'd6, 8'h80,   9,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{3'd7, 8'd3,   8'd200, 3'd7, 8'h80,   1,  1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{3'd6, 8'd16,  8'd16,  3'd0, 8'd0,    10, 1'b1, 1'b0, 1'b1, 1'b1};

    resetN = 1'b0; start = 1'b0; aluOp = '0; operandA = '0; operandB = '0; destIn = '0;
    model_reset();
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_regWrite", regWrite, 0);
    check("rst_writeRegister", writeRegister, 0);
    check("rst_flags", {zeroFlag, carryFlag, ltFlag}, 0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 16; i++) begin
      model_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, wr);
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, (i % 3) == 0, tbl[i].res, tbl[i].lat,
             tbl[i].z, tbl[i].c, tbl[i].lt, tbl[i].wr);
    end

    // start held into the DONE cycle must not launch a second op
    model_op(0, 1, 2, lat, wr);
    aluOp = 3'd0; operandA = 8'd1; operandB = 8'd2; destIn = 3'd1; start = 1'b1;
    @(negedge clock);
    check("hold_first_done", done, 1);
    check("hold_first_result", result, 3);
    aluOp = 3'd1; operandA = 8'd50; operandB = 8'd1;
    @(negedge clock);
    start = 1'b0;
    check("hold_no_second_done", done, 0);
    @(negedge clock);
    check("hold_still_idle", done, 0);
    check("hold_result_kept", result, 3);

    // spurious start and operand change during MUL are ignored
    model_op(6, 13, 11, lat, wr);
    aluOp = 3'd6; operandA = 8'd13; operandB = 8'd11; destIn = 3'd6; start = 1'b1;
    ndone = 0; done_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (c == 1) start = 1'b0;
      if (done) begin
        ndone++;
        done_cyc = c;
        check("mul_intr_result", result, 143);
      end
      if (c == 3) begin start = 1'b1; aluOp = 3'd0; operandA = 8'd99; operandB = 8'd1; end
      if (c == 4) start = 1'b0;
    end
    check("mul_intr_done_count", ndone, 1);
    check("mul_intr_done_cycle", done_cyc, 10);

    // reset mid-MUL aborts with no write afterwards
    aluOp = 3'd6; operandA = 8'd13; operandB = 8'd11; destIn = 3'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b0;
    model_reset();
    #1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_outputs", {done, regWrite, writeRegister, zeroFlag, carryFlag, ltFlag}, 0);
    @(negedge clock);
    resetN = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (done || regWrite) ndone++;
    end
    check("abort_no_write", ndone, 0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      logic [2:0] d;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      d  = 3'($urandom);
      if (($urandom % 4) == 0) a = 8'd0;
      if (($urandom % 5) == 0) b = a;
      model_op(op, a, b, lat, wr);
      run_op(op, a, b, d, ($urandom % 2) == 1, m_res, lat, m_z, m_c, m_lt, wr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
